acc_bitserial_sched: RTL
========================

Name: acc_bitserial_sched

Overview:
Sequencer for the bit-serial shift accumulator in the digital CIM datapath. It accepts one MAC command, issues input bit-planes MSB-first to the macro/global_io path, and aligns the accumulator's start_acc pulse to the macro's psum latency. It captures the accumulator's one-cycle-valid nout into a held result register. The result is returned on a valid/ready handshake.

Parameters:
OUTPUT_WIDTH, 51, width of accumulator nout and res_data
MAX_BITS, 24, maximum input bit-planes per command (OUTPUT_WIDTH-27)
CNT_W, 5, bit-count width, >= clog2(MAX_BITS+1)
PSUM_LAT, 2, cycles from bit_idx issue to matching psum at accumulator input; legal range >= 1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
soft_clr  in  1  synchronous abort; returns to IDLE and drops res_valid
cmd_valid  in  1  command request
cmd_ready  out  1  command accept; high only when IDLE and !res_valid
cmd_nbits  in  CNT_W  number of bit-planes N; 0 legal; values > MAX_BITS clamp to MAX_BITS
cmd_signed  in  1  input is two's complement; MSB plane is negatively weighted
bit_en  out  1  a bit-plane is issued this cycle
bit_idx  out  CNT_W  plane index being issued, N-1 down to 0
msb_neg  out  1  high with the MSB plane issue when signed; global_io negates that psum
start_acc  out  1  to accumulator: clear, one-cycle pulse
acc_nout  in  OUTPUT_WIDTH  accumulator nout
res_valid  out  1  result held
res_ready  in  1  result consumed
res_data  out  OUTPUT_WIDTH  captured result
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, except cmd_ready, which is 1 because the block resets to IDLE with no result held. All outputs are registered except cmd_ready and busy, which decode state.
- Cycle 0 is the accept cycle (cmd_valid & cmd_ready). At accept, latch N_eff = min(cmd_nbits, MAX_BITS) and cmd_signed.
- States and transitions:
  - IDLE -> ISSUE if N_eff > 0, otherwise IDLE -> FLUSH.
  - ISSUE covers cycles 1..N_eff: bit_en=1 and bit_idx = N_eff - c. msb_neg = latched_signed in cycle 1 only.
  - FLUSH covers the next PSUM_LAT cycles: bit_en=0, bit_idx=0.
  - CAPT lasts one cycle (cycle N_eff+PSUM_LAT+1). res_data <= acc_nout at the end of CAPT. res_valid=1 from cycle N_eff+PSUM_LAT+2. Then -> IDLE.
- start_acc is high exactly in cycle PSUM_LAT. This is independent of state, so it may overlap ISSUE or FLUSH. Generate it by delaying the accept pulse through a PSUM_LAT-deep shift register.
- Accumulator contract:
  - It clears on start_acc.
  - In cycles PSUM_LAT+1..PSUM_LAT+N_eff it computes acc = (acc<<1) + sext(psum).
  - nout equals the result only during CAPT; the block must not sample it in any other cycle.
- N_eff=0: result is 0 and is captured in cycle PSUM_LAT+1.
- Result handshake: res_valid drops on the cycle after res_valid & res_ready. res_data holds stable while res_valid=1. cmd_ready stays 0 until res_valid drops, so a new op cannot overwrite an unconsumed result.
- soft_clr has priority over everything:
  - state -> IDLE; the start pipe, res_valid, bit_en and msb_neg are cleared; res_data is kept.
  - A cmd_valid in the same cycle is not accepted.
- rst_n asserted mid-op aborts immediately. The accumulator's stale contents are harmless because the next op always pulses start_acc.
- Counter arithmetic is unsigned CNT_W bits. The counter never wraps because N_eff <= MAX_BITS < 2^CNT_W.

Decomposition:
- Package acc_sched_pkg:
  - state enum {IDLE, ISSUE, FLUSH, CAPT}
  - defaults MAX_BITS_DEF=24, OUTPUT_WIDTH_DEF=51
  - clog2-based CNT_W helper
- One sub-module, acc_sched_dly: a parameterized 1-bit, PSUM_LAT-stage shift register with async reset and sync clear, used for start_acc.
- The FSM, counter and result register stay in the top.

Test Plan:
- Test bench: real accumulator instance plus a psum model with PSUM_LAT=2.
- Unsigned: N=4, plane psums 5,-3,2,1 (MSB first). Expected: start_acc in cycle 2, bit_idx 3,2,1,0 in cycles 1-4, res_data=33 with res_valid rising in cycle 8.
- Signed: N=3, cmd_signed=1. Expected: msb_neg high only in cycle 1 with bit_idx=2, and low in all other cycles.
- Zero planes and clamp:
  - N=0: bit_en never high, res_data=0, res_valid in cycle 4.
  - cmd_nbits=31: exactly 24 bit_en cycles, bit_idx 23..0.
- Backpressure: hold res_ready=0 for 5 cycles with a second cmd_valid pending. Expected: cmd_ready=0, res_data stable; second op accepted the cycle after the handshake.
- Abort:
  - soft_clr in cycle 2 of N=8: IDLE next cycle, no res_valid, start_acc never fires late.
  - rst_n low mid-ISSUE: all outputs 0, cmd_ready=1 after release.

Source files
------------

// File: rtl/acc_sched_pkg.sv
// ============================================================================
// Module  : acc_sched_pkg
// Brief   : Shared types and defaults for the bit-serial accumulator sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package acc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FLUSH = 2'd2,
    CAPT  = 2'd3
  } sched_state_t;

  localparam int MAX_BITS_DEF     = 24;
  localparam int OUTPUT_WIDTH_DEF = 51;

  // Bit-count width able to hold 0..max_bits inclusive.
  function automatic int cnt_w(input int max_bits);
    return $clog2(max_bits + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/acc_bitserial_sched_if.sv
// ============================================================================
// Module  : acc_bitserial_sched_if
// Brief   : Command request and result return handshakes of the sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface acc_bitserial_sched_if
  import acc_sched_pkg::*;
#(
  parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int CNT_W        = 5
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [CNT_W-1:0]        cmd_nbits;
  logic                    cmd_signed;
  logic                    res_valid;
  logic                    res_ready;
  logic [OUTPUT_WIDTH-1:0] res_data;

  modport master (
    output cmd_valid, cmd_nbits, cmd_signed, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_nbits, cmd_signed, res_ready,
    output cmd_ready, res_valid, res_data
  );

endinterface

`default_nettype wire

// File: rtl/acc_sched_dly.sv
// ============================================================================
// Module  : acc_sched_dly
// Brief   : 1-bit STAGES-deep delay line, async reset and synchronous clear.
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc_sched_dly #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic clr,
  input  wire logic din,
  output logic      dout
);

  logic [STAGES-1:0] r_sr;

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   r_sr <= '0;
        else if (clr) r_sr <= '0;
        else          r_sr <= din;
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   r_sr <= '0;
        else if (clr) r_sr <= '0;
        else          r_sr <= {r_sr[STAGES-2:0], din};
      end
    end
  endgenerate

  assign dout = r_sr[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/acc_bitserial_sched.sv
// ============================================================================
// Module  : acc_bitserial_sched
// Brief   : Issues bit-planes MSB-first, times start_acc to the psum latency
//           and returns the captured accumulator result on valid/ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module acc_bitserial_sched
  import acc_sched_pkg::*;
#(
  parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
  parameter int MAX_BITS     = MAX_BITS_DEF,
  parameter int CNT_W        = cnt_w(MAX_BITS_DEF),
  parameter int PSUM_LAT     = 2
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    soft_clr,
  acc_bitserial_sched_if.slave         bus,
  output logic                         bit_en,
  output logic [CNT_W-1:0]             bit_idx,
  output logic                         msb_neg,
  output logic                         start_acc,
  input  wire logic [OUTPUT_WIDTH-1:0] acc_nout,
  output logic                         busy
);

  localparam logic [CNT_W-1:0] c_MAX      = CNT_W'(MAX_BITS);
  localparam int               c_FW       = (PSUM_LAT > 1) ? $clog2(PSUM_LAT) : 1;
  localparam logic [c_FW-1:0]  c_FL_LOAD  = c_FW'(PSUM_LAT - 1);

  sched_state_t            r_state;
  logic                    r_bit_en;
  logic [CNT_W-1:0]        r_bit_idx;
  logic                    r_msb_neg;
  logic [c_FW-1:0]         r_fcnt;
  logic                    r_res_valid;
  logic [OUTPUT_WIDTH-1:0] r_res_data;

  logic                    w_cmd_ready;
  logic                    w_accept;
  logic [CNT_W-1:0]        w_neff;

  assign w_cmd_ready = (r_state == IDLE) && !r_res_valid;
  assign w_accept    = bus.cmd_valid && w_cmd_ready && !soft_clr;
  assign w_neff      = (bus.cmd_nbits > c_MAX) ? c_MAX : bus.cmd_nbits;

  // start_acc is tied to the accept pulse, not to the state, so it lands in
  // the right cycle even when it overlaps ISSUE or FLUSH.
  acc_sched_dly #(
    .STAGES (PSUM_LAT)
  ) u_start_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (soft_clr),
    .din   (w_accept),
    .dout  (start_acc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_en    <= 1'b0;
      r_bit_idx   <= '0;
      r_msb_neg   <= 1'b0;
      r_fcnt      <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else if (soft_clr) begin
      r_state     <= IDLE;
      r_bit_en    <= 1'b0;
      r_bit_idx   <= '0;
      r_msb_neg   <= 1'b0;
      r_fcnt      <= '0;
      r_res_valid <= 1'b0;
    end else begin
      if (r_res_valid && bus.res_ready) begin
        r_res_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_neff != '0) begin
              r_state   <= ISSUE;
              r_bit_en  <= 1'b1;
              r_bit_idx <= w_neff - CNT_W'(1);
              r_msb_neg <= bus.cmd_signed;
            end else begin
              r_state   <= FLUSH;
              r_fcnt    <= c_FL_LOAD;
            end
          end
        end
        ISSUE: begin
          r_msb_neg <= 1'b0;
          if (r_bit_idx == '0) begin
            r_bit_en <= 1'b0;
            r_state  <= FLUSH;
            r_fcnt   <= c_FL_LOAD;
          end else begin
            r_bit_idx <= r_bit_idx - CNT_W'(1);
          end
        end
        FLUSH: begin
          if (r_fcnt == '0) r_state <= CAPT;
          else              r_fcnt  <= r_fcnt - c_FW'(1);
        end
        CAPT: begin
          // Only cycle in which the accumulator output is the final sum.
          r_res_data  <= acc_nout;
          r_res_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_data  = r_res_data;
  assign bit_en        = r_bit_en;
  assign bit_idx       = r_bit_idx;
  assign msb_neg       = r_msb_neg;
  assign busy          = (r_state != IDLE);

endmodule

`default_nettype wire
